// File: rtl/mips_mc_controller_pkg.sv
// Shared control definitions for the multicycle MIPS core: FSM states,
// opcode/funct encodings and the ALU operation codes the ALU decodes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_IEXEC,
    S_IWB,
    S_BRANCH,
    S_JUMP
  } statetype_t;

  // Selects which rule the ALU decoder applies in the current state.
  typedef enum logic [1:0] {
    CLS_ADD,
    CLS_REXEC,
    CLS_IEXEC,
    CLS_BRANCH
  } aluclass_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;

  localparam logic [4:0] ALU_ADD = 5'b00010;
  localparam logic [4:0] ALU_SUB = 5'b00110;
  localparam logic [4:0] ALU_AND = 5'b00000;
  localparam logic [4:0] ALU_OR  = 5'b00001;
  localparam logic [4:0] ALU_XOR = 5'b00101;
  localparam logic [4:0] ALU_SLT = 5'b00111;
  localparam logic [4:0] ALU_SLL = 5'b01110;
  localparam logic [4:0] ALU_SRL = 5'b01000;
  localparam logic [4:0] ALU_SRA = 5'b11001;
  localparam logic [4:0] ALU_LUI = 5'b00011;

endpackage

// File: rtl/mips_mc_controller_if.sv
// Control/status bundle between the multicycle controller (master) and
// the datapath/IR/ALU side (slave).
interface mips_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic [4:0]       alucontrol;
  logic             alusrca;
  logic [1:0]       alusrcb;
  logic             extop;
  logic             iord;
  logic             irwrite;
  logic             memwrite;
  logic             regwrite;
  logic             regdst;
  logic             memtoreg;
  logic [1:0]       pcsrc;
  logic             pcen;
  logic             illegal_op;
  logic [CNT_W-1:0] instret;

  modport master (
    input  op, funct, zero,
    output alucontrol, alusrca, alusrcb, extop, iord, irwrite, memwrite,
           regwrite, regdst, memtoreg, pcsrc, pcen, illegal_op, instret
  );

  modport slave (
    output op, funct, zero,
    input  alucontrol, alusrca, alusrcb, extop, iord, irwrite, memwrite,
           regwrite, regdst, memtoreg, pcsrc, pcen, illegal_op, instret
  );
endinterface

// File: rtl/mips_mc_controller_aludec.sv
// ALU operation decoder: maps the state class plus op/funct onto the
// 5-bit alucontrol code and the immediate extension mode.
module mc_aludec
  import mips_ctrl_pkg::*;
(
  input  aluclass_t  cls,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [4:0] alucontrol,
  output logic       extop,
  output logic       bad_funct
);

  logic [4:0] ralu;

  always_comb begin
    ralu      = ALU_ADD;
    bad_funct = 1'b0;
    case (funct)
      F_ADD:   ralu = ALU_ADD;
      F_SUB:   ralu = ALU_SUB;
      F_AND:   ralu = ALU_AND;
      F_OR:    ralu = ALU_OR;
      F_XOR:   ralu = ALU_XOR;
      F_SLT:   ralu = ALU_SLT;
      F_SLL:   ralu = ALU_SLL;
      F_SRL:   ralu = ALU_SRL;
      F_SRA:   ralu = ALU_SRA;
      default: bad_funct = 1'b1;
    endcase
  end

  always_comb begin
    alucontrol = ALU_ADD;
    extop      = 1'b1;
    case (cls)
      CLS_REXEC:  alucontrol = ralu;
      CLS_BRANCH: alucontrol = ALU_SUB;
      CLS_IEXEC: begin
        case (op)
          OP_SLTI: alucontrol = ALU_SLT;
          OP_ANDI: begin alucontrol = ALU_AND; extop = 1'b0; end
          OP_ORI:  begin alucontrol = ALU_OR;  extop = 1'b0; end
          OP_XORI: begin alucontrol = ALU_XOR; extop = 1'b0; end
          OP_LUI:  alucontrol = ALU_LUI;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM sequencing each instruction and
// driving datapath enables/selects, plus a retired-instruction counter.
module mips_mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  mips_ctrl_if.master bus
);

  statetype_t       state, nextstate;
  aluclass_t        cls;
  logic             bad_funct;
  logic             pcwrite, irwrite_s, regwrite_s, memwrite_s, illegal_s;
  logic             alusrca_s, iord_s, regdst_s, memtoreg_s;
  logic [1:0]       alusrcb_s, pcsrc_s;
  logic             branch_taken, retire;
  logic [CNT_W-1:0] instret_q;

  mc_aludec u_aludec (
    .cls        (cls),
    .op         (bus.op),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol),
    .extop      (bus.extop),
    .bad_funct  (bad_funct)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= nextstate;
  end

  always_comb begin
    nextstate = S_FETCH;
    case (state)
      S_FETCH: nextstate = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW:   nextstate = S_MEMADR;
          OP_R:           nextstate = bad_funct ? S_FETCH : S_EXECUTE;
          OP_BEQ, OP_BNE: nextstate = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                          nextstate = S_IEXEC;
          OP_J:           nextstate = S_JUMP;
          default:        nextstate = S_FETCH;
        endcase
      end
      S_MEMADR:  nextstate = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   nextstate = S_MEMWB;
      S_EXECUTE: nextstate = S_ALUWB;
      S_IEXEC:   nextstate = S_IWB;
      default:   nextstate = S_FETCH;
    endcase
  end

  always_comb begin
    cls        = CLS_ADD;
    pcwrite    = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    illegal_s  = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    iord_s     = 1'b0;
    regdst_s   = 1'b0;
    memtoreg_s = 1'b0;
    pcsrc_s    = 2'b00;
    case (state)
      S_FETCH: begin
        alusrcb_s = 2'b01;
        irwrite_s = 1'b1;
        pcwrite   = 1'b1;
      end
      // DECODE only falls back to FETCH when op/funct is undecodable
      S_DECODE: begin
        alusrcb_s = 2'b11;
        illegal_s = (nextstate == S_FETCH);
      end
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      S_MEMRD: iord_s = 1'b1;
      S_MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTE: begin
        alusrca_s = 1'b1;
        cls       = CLS_REXEC;
      end
      S_ALUWB: begin
        regdst_s   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_IEXEC: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        cls       = CLS_IEXEC;
      end
      S_IWB: regwrite_s = 1'b1;
      S_BRANCH: begin
        alusrca_s = 1'b1;
        cls       = CLS_BRANCH;
        pcsrc_s   = 2'b01;
      end
      S_JUMP: begin
        pcsrc_s = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign branch_taken = (state == S_BRANCH) &&
                        (((bus.op == OP_BEQ) &&  bus.zero) ||
                         ((bus.op == OP_BNE) && !bus.zero));

  // Architectural write strobes are held off for as long as reset is low
  assign bus.pcen       = reset & (pcwrite | branch_taken);
  assign bus.irwrite    = reset & irwrite_s;
  assign bus.regwrite   = reset & regwrite_s;
  assign bus.memwrite   = reset & memwrite_s;
  assign bus.illegal_op = reset & illegal_s;
  assign bus.alusrca    = alusrca_s;
  assign bus.alusrcb    = alusrcb_s;
  assign bus.iord       = iord_s;
  assign bus.regdst     = regdst_s;
  assign bus.memtoreg   = memtoreg_s;
  assign bus.pcsrc      = pcsrc_s;

  always_comb begin
    retire = 1'b0;
    case (state)
      S_MEMWB, S_MEMWR, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: retire = 1'b1;
      default: retire = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign bus.instret = instret_q;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: directed and random
// instructions checked per cycle against an instruction-level reference.
module tb_mips_mc_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_ctrl_if #(.CNT_W(32)) bus ();

  mips_mc_controller #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [31:0] model_ret = '0;

  typedef struct {
    int         cpi;
    int         regw;
    int         memw;
    int         pcj;
    int         ill;
    bit         is_r;
    bit         is_i;
    bit         is_br;
    bit         is_j;
    bit         is_lw;
    logic [4:0] alu;
    logic       ext;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction-level reference: cost and observable effects of one instruction
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    exp_t e;
    e = '{cpi: 2, regw: 0, memw: 0, pcj: 0, ill: 1, is_r: 0, is_i: 0, is_br: 0,
          is_j: 0, is_lw: 0, alu: 5'b00010, ext: 1'b1};
    case (op)
      6'b100011: begin e.cpi = 5; e.regw = 1; e.ill = 0; e.is_lw = 1; end
      6'b101011: begin e.cpi = 4; e.memw = 1; e.ill = 0; end
      6'b000100: begin e.cpi = 3; e.pcj = int'(zero);  e.ill = 0; e.is_br = 1; end
      6'b000101: begin e.cpi = 3; e.pcj = int'(!zero); e.ill = 0; e.is_br = 1; end
      6'b000010: begin e.cpi = 3; e.pcj = 1; e.ill = 0; e.is_j = 1; end
      6'b001000: begin e.is_i = 1; e.alu = 5'b00010; end
      6'b001010: begin e.is_i = 1; e.alu = 5'b00111; end
      6'b001100: begin e.is_i = 1; e.alu = 5'b00000; e.ext = 1'b0; end
      6'b001101: begin e.is_i = 1; e.alu = 5'b00001; e.ext = 1'b0; end
      6'b001110: begin e.is_i = 1; e.alu = 5'b00101; e.ext = 1'b0; end
      6'b001111: begin e.is_i = 1; e.alu = 5'b00011; end
      6'b000000: begin
        e.is_r = 1;
        case (funct)
          6'b100000: e.alu = 5'b00010;
          6'b100010: e.alu = 5'b00110;
          6'b100100: e.alu = 5'b00000;
          6'b100101: e.alu = 5'b00001;
          6'b100110: e.alu = 5'b00101;
          6'b101010: e.alu = 5'b00111;
          6'b000000: e.alu = 5'b01110;
          6'b000010: e.alu = 5'b01000;
          6'b000011: e.alu = 5'b11001;
          default:   e.is_r = 0;
        endcase
      end
      default: ;
    endcase
    if (e.is_i || e.is_r) begin e.cpi = 4; e.regw = 1; e.ill = 0; end
    return e;
  endfunction

  // Called just after a falling edge while the DUT sits in FETCH
  task automatic exec(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    exp_t e;
    int c, rw, mw, pj, il;
    bit done;
    e = model(op, funct, zero);
    c = 0; rw = 0; mw = 0; pj = 0; il = 0; done = 0;
    bus.op = op; bus.funct = funct; bus.zero = zero;
    #1;
    while (!done && c < 12) begin
      c++;
      if (c == 1) begin
        chk("fetch_irwrite", 32'(bus.irwrite), 32'd1);
        chk("fetch_pcen", 32'(bus.pcen), 32'd1);
        chk("fetch_alusrcb", 32'(bus.alusrcb), 32'd1);
        chk("fetch_alu", 32'(bus.alucontrol), 32'h02);
        chk("fetch_iord", 32'(bus.iord), 32'd0);
      end
      if (c == 2) begin
        chk("decode_alusrcb", 32'(bus.alusrcb), 32'd3);
        chk("decode_irwrite", 32'(bus.irwrite), 32'd0);
      end
      if (c == 3 && (e.is_r || e.is_i)) begin
        chk("exec_alu", 32'(bus.alucontrol), 32'(e.alu));
        chk("exec_extop", 32'(bus.extop), 32'(e.ext));
        chk("exec_alusrca", 32'(bus.alusrca), 32'd1);
        chk("exec_alusrcb", 32'(bus.alusrcb), e.is_r ? 32'd0 : 32'd2);
      end
      if (c == 3 && e.is_br) begin
        chk("branch_pcen", 32'(bus.pcen), 32'(e.pcj));
        chk("branch_pcsrc", 32'(bus.pcsrc), 32'd1);
        chk("branch_alu", 32'(bus.alucontrol), 32'h06);
      end
      if (c == 3 && e.is_j) chk("jump_pcsrc", 32'(bus.pcsrc), 32'd2);
      if (c == 4 && e.is_lw) chk("memrd_iord", 32'(bus.iord), 32'd1);
      if (bus.regwrite) begin
        chk("wb_regdst", 32'(bus.regdst), 32'(e.is_r));
        chk("wb_memtoreg", 32'(bus.memtoreg), 32'(e.is_lw));
      end
      if (bus.memwrite) chk("memwr_iord", 32'(bus.iord), 32'd1);
      if (c >= 2) begin
        rw += int'(bus.regwrite);
        mw += int'(bus.memwrite);
        pj += int'(bus.pcen);
      end
      il += int'(bus.illegal_op);
      @(posedge clk);
      @(negedge clk);
      #1;
      if (bus.irwrite) done = 1;
    end
    chk("cycles", done ? 32'(c) : 32'hDEAD, 32'(e.cpi));
    chk("regwrite_count", 32'(rw), 32'(e.regw));
    chk("memwrite_count", 32'(mw), 32'(e.memw));
    chk("late_pcen_count", 32'(pj), 32'(e.pcj));
    chk("illegal_pulses", 32'(il), 32'(e.ill));
    if (e.ill == 0) model_ret++;
    chk("instret", bus.instret, model_ret);
  endtask

  logic [5:0] ops [12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000,
                           6'b001010, 6'b001100, 6'b001101, 6'b001110, 6'b001111, 6'b000010};
  logic [5:0] fns [9]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                           6'b101010, 6'b000000, 6'b000010, 6'b000011};

  initial begin
    logic [5:0] rop, rfn;
    reset = 1'b0;
    bus.op = 6'b000000; bus.funct = 6'b100000; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset_instret", bus.instret, 32'd0);
    chk("reset_irwrite", 32'(bus.irwrite), 32'd0);
    chk("reset_pcen", 32'(bus.pcen), 32'd0);
    chk("reset_alusrcb", 32'(bus.alusrcb), 32'd1);
    reset = 1'b1;

    exec(6'b100011, 6'b000000, 1'b0);   // lw
    exec(6'b101011, 6'b000000, 1'b0);   // sw
    exec(6'b000000, 6'b000011, 1'b0);   // sra
    exec(6'b000000, 6'b000000, 1'b1);   // sll
    exec(6'b000000, 6'b101010, 1'b0);   // slt
    exec(6'b000100, 6'b000000, 1'b1);   // beq taken
    exec(6'b000100, 6'b000000, 1'b0);   // beq not taken
    exec(6'b000101, 6'b000000, 1'b1);   // bne not taken
    exec(6'b000101, 6'b000000, 1'b0);   // bne taken
    exec(6'b001101, 6'b000000, 1'b0);   // ori
    exec(6'b001000, 6'b000000, 1'b0);   // addi
    exec(6'b001111, 6'b000000, 1'b0);   // lui
    exec(6'b000010, 6'b000000, 1'b0);   // j
    exec(6'b111111, 6'b000000, 1'b0);   // illegal op
    exec(6'b000000, 6'b111111, 1'b0);   // illegal funct

    // Reset asserted while a lw sits in MEMRD
    bus.op = 6'b100011; bus.funct = 6'b000000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("pre_reset_iord", 32'(bus.iord), 32'd1);
    reset = 1'b0;
    #1;
    chk("midreset_instret", bus.instret, 32'd0);
    chk("midreset_iord", 32'(bus.iord), 32'd0);
    chk("midreset_alusrcb", 32'(bus.alusrcb), 32'd1);
    chk("midreset_alu", 32'(bus.alucontrol), 32'h02);
    chk("midreset_irwrite", 32'(bus.irwrite), 32'd0);
    chk("midreset_pcen", 32'(bus.pcen), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("held_regwrite", 32'(bus.regwrite), 32'd0);
    chk("held_memwrite", 32'(bus.memwrite), 32'd0);
    chk("held_pcen", 32'(bus.pcen), 32'd0);
    chk("held_instret", bus.instret, 32'd0);
    reset = 1'b1;
    model_ret = '0;
    exec(6'b100011, 6'b000000, 1'b0);

    for (int i = 0; i < 80; i++) begin
      rop = ops[$urandom_range(11)];
      rfn = fns[$urandom_range(8)];
      if ($urandom_range(9) == 0) rop = 6'($urandom);
      if ($urandom_range(7) == 0) rfn = 6'($urandom);
      exec(rop, rfn, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
